// File: rtl/risc_main_ctrl_if.sv
// Instruction/data memory handshake bundle between the main control unit and memory.
interface risc_main_ctrl_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, imem_rdata, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/risc_main_ctrl.sv
// KGP-RISC multi-cycle main control: fetch handshake, decode, and EXEC/MEM/WB sequencing.
module risc_main_ctrl #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  risc_main_ctrl_if.master bus,
  input  logic            alu_zero,
  input  logic            alu_neg,
  output logic [XLEN-1:0] instr,
  output logic [2:0]      ALUop,
  output logic [3:0]      fCode,
  output logic            reg_wr,
  output logic [1:0]      wb_sel,
  output logic            pc_wr,
  output logic [1:0]      pc_src,
  output logic            illegal,
  output logic            halted
);
  localparam logic [5:0] OP_R = 6'd0, OP_I = 6'd1, OP_SH = 6'd2, OP_LD = 6'd3,
                         OP_ST = 6'd4, OP_BR = 6'd5, OP_J = 6'd6, OP_HALT = 6'h3f;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state;

  logic [5:0] opcode, rd_op;
  logic       legal, taken;
  assign opcode = instr[31:26];
  assign rd_op  = bus.imem_rdata[31:26];
  assign legal  = (opcode <= OP_J) || (opcode == OP_HALT);

  always_comb begin
    case (fCode)
      4'd0:    taken = alu_neg;
      4'd1:    taken = alu_zero;
      4'd2:    taken = !alu_zero;
      default: taken = 1'b0;
    endcase
  end

  function automatic logic [2:0] alu_class(input logic [5:0] op);
    case (op)
      OP_R:         return 3'b000;
      OP_I:         return 3'b001;
      OP_SH:        return 3'b010;
      OP_LD, OP_ST: return 3'b011;
      OP_BR:        return 3'b100;
      OP_J:         return 3'b101;
      default:      return 3'b000;
    endcase
  endfunction

  // ALUop/fCode are captured with the IR so they are already valid during DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      instr <= '0;
      ALUop <= '0;
      fCode <= '0;
    end else begin
      case (state)
        FETCH: if (bus.imem_ack) begin
          instr <= bus.imem_rdata;
          ALUop <= alu_class(rd_op);
          fCode <= bus.imem_rdata[3:0];
          state <= DECODE;
        end
        DECODE: state <= (opcode == OP_HALT) ? HALT : EXEC;
        EXEC: begin
          case (opcode)
            OP_R, OP_I, OP_SH: state <= WB;
            OP_LD, OP_ST:      state <= MEM;
            OP_J:              state <= (fCode == 4'd1) ? WB : FETCH;
            default:           state <= FETCH;
          endcase
        end
        MEM:     if (bus.dmem_ack) state <= (opcode == OP_LD) ? WB : FETCH;
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes decode straight from state so reset kills them without waiting for a clock.
  assign bus.imem_req = rst && (state == FETCH);
  assign bus.dmem_req = rst && (state == MEM);
  assign bus.dmem_we  = bus.dmem_req && (opcode == OP_ST);

  always_comb begin
    reg_wr  = 1'b0;
    wb_sel  = 2'b00;
    pc_wr   = 1'b0;
    pc_src  = 2'b00;
    illegal = 1'b0;
    halted  = 1'b0;
    if (rst) begin
      case (state)
        DECODE: illegal = !legal;
        EXEC: begin
          case (opcode)
            OP_BR: begin
              pc_wr  = 1'b1;
              pc_src = taken ? 2'b01 : 2'b00;
            end
            OP_J: begin
              if (fCode == 4'd2) begin
                pc_wr  = 1'b1;
                pc_src = 2'b10;
              end else if (fCode != 4'd1) begin
                pc_wr  = 1'b1;
                pc_src = 2'b01;
              end
            end
            OP_R, OP_I, OP_SH, OP_LD, OP_ST: pc_wr = 1'b0;
            default: pc_wr = 1'b1;  // undefined opcode retires as a NOP
          endcase
        end
        MEM: pc_wr = bus.dmem_ack && (opcode == OP_ST);
        WB: begin
          reg_wr = 1'b1;
          pc_wr  = 1'b1;
          wb_sel = (opcode == OP_LD) ? 2'b01 : (opcode == OP_J) ? 2'b10 : 2'b00;
          pc_src = (opcode == OP_J) ? 2'b01 : 2'b00;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
